// File: rtl/audio_frame_scheduler_pkg.sv
// audio_frame_scheduler_pkg: shared state encoding and status bit positions
//   state_t     scheduler states S_RESET..S_RUN
//   ST_*        bit positions inside the 32-bit status word
package audio_frame_scheduler_pkg;
    typedef enum logic [2:0] {S_RESET, S_IDLE, S_WAIT, S_START, S_RUN} state_t;
    localparam int ST_BUSY    = 0;
    localparam int ST_PENDING = 1;
    localparam int ST_TIMEOUT = 2;
    localparam int ST_FRAME   = 16;
    localparam int ST_OVR     = 24;
endpackage

// File: rtl/audio_frame_scheduler_if.sv
// audio_frame_scheduler_if: host/I2S/sequencer signals of the frame scheduler
//   enable, soft_reset, clear_flags   host control
//   frame_tick                        per-frame strobe from I2S Rx
//   engine_done                       sequencer completion
//   engine_rst, engine_start, frame   sequencer control
//   busy, timeout_flag, overrun_count, status   host status
interface audio_frame_scheduler_if #(
    parameter int FRAMES = 32,
    parameter int OVR_W  = 8
);
    logic                      enable;
    logic                      soft_reset;
    logic                      clear_flags;
    logic                      frame_tick;
    logic                      engine_done;
    logic                      engine_rst;
    logic                      engine_start;
    logic [$clog2(FRAMES)-1:0] frame;
    logic                      busy;
    logic                      timeout_flag;
    logic [OVR_W-1:0]          overrun_count;
    logic [31:0]               status;
    modport master (
        output enable, soft_reset, clear_flags, frame_tick, engine_done,
        input  engine_rst, engine_start, frame, busy, timeout_flag, overrun_count, status
    );
    modport slave (
        input  enable, soft_reset, clear_flags, frame_tick, engine_done,
        output engine_rst, engine_start, frame, busy, timeout_flag, overrun_count, status
    );
endinterface

// File: rtl/audio_frame_scheduler_cycle_timer.sv
// audio_frame_scheduler_cycle_timer: clearable up-counter with terminal-count compare
//   ck, rst   negedge clock, async active-high reset
//   clr       restart counting from 0 on the next edge
//   last      terminal value
//   tc        count == last
module audio_frame_scheduler_cycle_timer #(
    parameter int W = 10
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] last,
    output logic         tc
);
    logic [W-1:0] count;
    always_ff @(negedge ck or posedge rst)
        if (rst) count <= '0;
        else count <= clr ? '0 : count + 1'b1;
    assign tc = count == last;
endmodule

// File: rtl/audio_frame_scheduler.sv
// audio_frame_scheduler: starts the audio sequencer once per sample frame
//   ck, rst   negedge clock, async active-high reset
//   bus       host control/status, frame tick, sequencer start/done/reset
module audio_frame_scheduler
    import audio_frame_scheduler_pkg::*;
#(
    parameter int FRAMES       = 32,
    parameter int RESET_CYCLES = 4,
    parameter int TIMEOUT      = 1024,
    parameter int OVR_W        = 8
) (
    input logic                    ck,
    input logic                    rst,
    audio_frame_scheduler_if.slave bus
);
    localparam int FW = $clog2(FRAMES);
    localparam int TW = $clog2(TIMEOUT > RESET_CYCLES ? TIMEOUT : RESET_CYCLES);
    state_t           state, nxt;
    logic [FW-1:0]    frame, frame_nxt;
    logic [OVR_W-1:0] overrun_count, ovr_base, ovr_nxt;
    logic [TW-1:0]    tmr_last;
    logic [31:0]      status;
    logic pending, pend_nxt, timeout_flag, engine_start, busy, engine_rst;
    logic tick_busy, drop, done, fire, tc, tmr_clr;
    // One timer serves both the reset stretch and the run watchdog; the two never overlap.
    audio_frame_scheduler_cycle_timer #(.W(TW)) u_timer (
        .ck   (ck),
        .rst  (rst),
        .clr  (tmr_clr),
        .last (tmr_last),
        .tc   (tc)
    );
    always_comb begin
        tick_busy = bus.frame_tick && (state == S_START || state == S_RUN) && !bus.soft_reset;
        drop      = tick_busy && pending;
        done      = state == S_RUN && bus.engine_done;
        fire      = state == S_RUN && !bus.engine_done && tc && !bus.soft_reset;
        tmr_last  = state == S_RESET ? TW'(RESET_CYCLES - 1) : TW'(TIMEOUT - 1);
        nxt       = state;
        pend_nxt  = pending | tick_busy;
        if (bus.soft_reset) begin
            nxt      = S_RESET;
            pend_nxt = 1'b0;
        end else begin
            case (state)
                S_RESET: begin
                    pend_nxt = 1'b0;
                    if (tc) nxt = bus.enable ? S_WAIT : S_IDLE;
                end
                S_IDLE:  nxt = bus.enable ? S_WAIT : S_IDLE;
                S_WAIT: begin
                    if (bus.frame_tick || pending) begin
                        nxt      = S_START;
                        pend_nxt = 1'b0;
                    end else if (!bus.enable) nxt = S_IDLE;
                end
                S_START: nxt = S_RUN;
                S_RUN: begin
                    // A tick landing with done is already folded into pend_nxt, so it restarts at once.
                    if (done) begin
                        nxt      = (pend_nxt && bus.enable) ? S_START : bus.enable ? S_WAIT : S_IDLE;
                        pend_nxt = 1'b0;
                    end else if (fire) begin
                        nxt      = S_RESET;
                        pend_nxt = 1'b0;
                    end
                end
                default: nxt = S_RESET;
            endcase
        end
        tmr_clr   = nxt != state || bus.soft_reset;
        frame_nxt = bus.soft_reset ? '0 : !done ? frame : (frame == FW'(FRAMES - 1)) ? '0 : frame + 1'b1;
        // A drop in the clearing cycle is still counted on top of the cleared value.
        ovr_base  = bus.clear_flags ? '0 : overrun_count;
        ovr_nxt   = (drop && !(&ovr_base)) ? ovr_base + 1'b1 : ovr_base;
    end
    always_ff @(negedge ck or posedge rst)
        if (rst) begin
            state         <= S_RESET;
            frame         <= '0;
            pending       <= 1'b0;
            timeout_flag  <= 1'b0;
            overrun_count <= '0;
            engine_start  <= 1'b0;
            busy          <= 1'b0;
            engine_rst    <= 1'b1;
        end else begin
            state         <= nxt;
            frame         <= frame_nxt;
            pending       <= pend_nxt;
            timeout_flag  <= fire | (timeout_flag & ~bus.clear_flags);
            overrun_count <= ovr_nxt;
            engine_start  <= nxt == S_START;
            busy          <= nxt == S_START || nxt == S_RUN;
            engine_rst    <= nxt == S_RESET;
        end
    always_comb begin
        status               = '0;
        status[ST_OVR +: 8]   = 8'(overrun_count);
        status[ST_FRAME +: 8] = 8'(frame);
        status[ST_TIMEOUT]    = timeout_flag;
        status[ST_PENDING]    = pending;
        status[ST_BUSY]       = busy;
    end
    assign bus.engine_rst    = engine_rst;
    assign bus.engine_start  = engine_start;
    assign bus.frame         = frame;
    assign bus.busy          = busy;
    assign bus.timeout_flag  = timeout_flag;
    assign bus.overrun_count = overrun_count;
    assign bus.status        = status;
endmodule

// File: tb/tb_audio_frame_scheduler.sv
// tb_audio_frame_scheduler: directed scenarios plus random traffic against a frame-level model
module tb_audio_frame_scheduler;
    localparam int FR = 32;
    localparam int RC = 4;
    localparam int TO = 16;
    localparam int OW = 8;
    localparam int OMAX = (1 << OW) - 1;
    logic ck = 1'b1;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    always #5 ck = ~ck;
    audio_frame_scheduler_if #(.FRAMES(FR), .OVR_W(OW)) bus ();
    audio_frame_scheduler #(.FRAMES(FR), .RESET_CYCLES(RC), .TIMEOUT(TO), .OVR_W(OW)) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask
    // Model: reset phase as remaining cycles, run as its age in cycles (-1 = not running).
    int m_rl, m_age, m_frame, m_ovr;
    bit m_idle, m_wait, m_start, m_pend, m_tf, m_ok = 0;
    always @(negedge ck) begin
        bit was_busy, fire, drop;
        was_busy = m_start || m_age >= 0;
        fire = 0;
        drop = 0;
        if (rst) begin
            m_rl = RC; m_age = -1; m_frame = 0; m_ovr = 0;
            m_idle = 0; m_wait = 0; m_start = 0; m_pend = 0; m_tf = 0; m_ok = 1;
        end else if (m_ok) begin
            if (bus.soft_reset) begin
                m_rl = RC; m_idle = 0; m_wait = 0; m_start = 0; m_age = -1; m_frame = 0; m_pend = 0;
            end else begin
                if (bus.frame_tick && was_busy) begin
                    drop = m_pend;
                    m_pend = 1;
                end
                if (m_rl > 0) begin
                    m_rl--;
                    m_pend = 0;
                    if (m_rl == 0) begin
                        m_wait = bus.enable;
                        m_idle = !bus.enable;
                    end
                end else if (m_idle) begin
                    if (bus.enable) begin m_idle = 0; m_wait = 1; end
                end else if (m_wait) begin
                    if (bus.frame_tick || m_pend) begin
                        m_wait = 0; m_start = 1; m_pend = 0;
                    end else if (!bus.enable) begin
                        m_wait = 0; m_idle = 1;
                    end
                end else if (m_start) begin
                    m_start = 0;
                    m_age = 0;
                end else if (m_age >= 0) begin
                    if (bus.engine_done) begin
                        m_frame = (m_frame + 1) % FR;
                        m_age = -1;
                        if (m_pend && bus.enable) m_start = 1;
                        else begin
                            m_wait = bus.enable;
                            m_idle = !bus.enable;
                        end
                        m_pend = 0;
                    end else if (m_age == TO - 1) begin
                        fire = 1; m_age = -1; m_pend = 0; m_rl = RC;
                    end else m_age++;
                end
            end
            if (bus.clear_flags) begin m_tf = 0; m_ovr = 0; end
            if (fire) m_tf = 1;
            if (drop && m_ovr < OMAX) m_ovr++;
        end
    end
    always @(posedge ck)
        if (m_ok) begin
            bit eb;
            eb = m_start || m_age >= 0;
            chk("engine_rst", bus.engine_rst, m_rl > 0);
            chk("engine_start", bus.engine_start, m_start);
            chk("frame", bus.frame, m_frame);
            chk("busy", bus.busy, eb);
            chk("timeout_flag", bus.timeout_flag, m_tf);
            chk("overrun_count", bus.overrun_count, m_ovr);
            chk("status", bus.status, {8'(m_ovr), 8'(m_frame), 13'h0, m_tf, m_pend, eb});
        end
    task automatic step(input bit t, input bit d, input bit s, input bit c);
        @(posedge ck);
        #1;
        bus.frame_tick = t;
        bus.engine_done = d;
        bus.soft_reset = s;
        bus.clear_flags = c;
    endtask
    task automatic wait_start(output int f);
        for (int n = 0; n < 10 && !bus.engine_start; n++) step(0, 0, 0, 0);
        chk("start_seen", bus.engine_start, 1);
        f = int'(bus.frame);
    endtask
    task automatic finish_run();
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
    endtask
    initial begin
        int f, n;
        bus.enable = 0; bus.frame_tick = 0; bus.engine_done = 0; bus.soft_reset = 0; bus.clear_flags = 0;
        repeat (3) step(0, 0, 0, 0);
        @(posedge ck);
        #1;
        rst = 0;
        bus.enable = 1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.engine_rst) n++;
            chk("t1_no_start", bus.engine_start, 0);
            step(0, 0, 0, 0);
        end
        chk("t1_rst_len", n, 4);
        step(1, 0, 0, 0);
        wait_start(f);
        chk("t2_frame0", f, 0);
        n = 1;
        repeat (9) begin step(0, 0, 0, 0); n += int'(bus.busy); end
        step(0, 1, 0, 0);
        n += int'(bus.busy);
        repeat (4) begin step(0, 0, 0, 0); n += int'(bus.busy); end
        chk("t2_busy_len", n, 11);
        chk("t2_frame1", bus.frame, 1);
        step(1, 0, 0, 0);
        wait_start(f);
        chk("t2_start_frame1", f, 1);
        finish_run();
        step(1, 0, 0, 0);
        wait_start(f);
        chk("t3_start_frame2", f, 2);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("t3_pending", bus.status[1], 1);
        chk("t3_overrun", bus.overrun_count, 1);
        step(0, 0, 0, 0);
        chk("t3_restart", bus.engine_start, 1);
        chk("t3_restart_frame", bus.frame, 3);
        finish_run();
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("t3_cleared", bus.overrun_count, 0);
        for (int i = 0; i < 32; i++) begin
            step(1, 0, 0, 0);
            wait_start(f);
            chk("t4_frame_seq", f, (4 + i) % 32);
            finish_run();
        end
        chk("t4_frame_end", bus.frame, 4);
        chk("t4_no_overrun", bus.overrun_count, 0);
        step(1, 0, 0, 0);
        wait_start(f);
        n = 0;
        while (!bus.timeout_flag && n < 40) begin step(0, 0, 0, 0); n++; end
        chk("t5_wd_cycles", n, TO + 1);
        chk("t5_flag", bus.status[2], 1);
        n = 0;
        repeat (8) begin
            if (bus.engine_rst) n++;
            step(0, 0, 0, 0);
        end
        chk("t5_rst_len", n, 4);
        chk("t5_frame_held", bus.frame, 4);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("t5_flag_clr", bus.status[2], 0);
        step(1, 0, 0, 0);
        wait_start(f);
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("t6_rst", bus.engine_rst, 1);
        chk("t6_frame0", bus.frame, 0);
        chk("t6_pend0", bus.status[1], 0);
        repeat (400) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("t6_saturate", bus.overrun_count, 255);
        step(0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) bus.enable = ~bus.enable;
            step($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0);
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
